// File: rtl/dpcm_2d_predictor.sv
// 2-D DPCM predictor: raster pixels in, signed residual x - P out, with left/up/avg/MED predictors.
// Build option DPCM_PRED_MODULO_EN folds the residual mod 2^PIX_W into a sign-extended PIX_W-bit value.
module dpcm_2d_predictor #(
    parameter int PIX_W  = 16,
    parameter int LINE_W = 640,
    parameter int ADDR_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [PIX_W-1:0] s_pixel,
    input  logic             s_sof,
    input  logic             s_eol,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [PIX_W:0]   m_residual,
    output logic             m_sof,
    output logic             m_eol,
    output logic             err_line
);

    typedef enum logic [1:0] {
        PRED_LEFT = 2'd0,
        PRED_UP   = 2'd1,
        PRED_AVG  = 2'd2,
        PRED_MED  = 2'd3
    } pred_t;

    typedef enum logic [1:0] {
        BORDER_ZERO,
        BORDER_LEFT,
        BORDER_UP,
        BORDER_NONE
    } border_t;

    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(LINE_W - 1);

    logic [ADDR_W-1:0] col;
    logic              first_row;
    pred_t             mode_q;

    logic              s1_valid;
    logic [PIX_W-1:0]  s1_x;
    logic [PIX_W-1:0]  s1_a;
    logic [PIX_W-1:0]  s1_b;
    logic [PIX_W-1:0]  s1_c;
    border_t           s1_border;
    pred_t             s1_mode;
    logic              s1_sof;
    logic              s1_eol;
    logic              s1_err;

    logic [PIX_W-1:0]  line_buf [LINE_W];

    logic              s1_en;
    logic              s2_en;
    logic              accept;
    logic [ADDR_W-1:0] eff_col;
    logic              eff_first;
    logic              len_err;
    border_t           border;
    logic [PIX_W-1:0]  max_ab;
    logic [PIX_W-1:0]  min_ab;
    logic [PIX_W-1:0]  pred;
    logic [PIX_W:0]    residual;

    // Each stage advances when it is empty or its successor is moving, so bubbles collapse under stall.
    assign s2_en   = !m_valid || m_ready;
    assign s1_en   = !s1_valid || s2_en;
    assign s_ready = s1_en;
    assign accept  = s_valid && s1_en;

    // A start-of-frame beat behaves as column 0 of the first row regardless of the counters.
    assign eff_col   = s_sof ? '0 : col;
    assign eff_first = s_sof || first_row;
    assign len_err   = s_eol ? (eff_col != LAST_COL) : (eff_col == LAST_COL);

    // NOTE: every signal assigned in always_comb gets a default first so no latch can be inferred.
    always_comb begin
        border = BORDER_NONE;
        if (eff_first && eff_col == '0)
            border = BORDER_ZERO;
        else if (eff_first)
            border = BORDER_LEFT;
        else if (eff_col == '0)
            border = BORDER_UP;
    end

    // NOTE: the line buffer and its read register carry no reset; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (accept) begin
            line_buf[eff_col] <= s_pixel;
            s1_b              <= line_buf[eff_col];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col       <= '0;
            first_row <= 1'b1;
            mode_q    <= PRED_LEFT;
            s1_valid  <= 1'b0;
            s1_x      <= '0;
            s1_a      <= '0;
            s1_c      <= '0;
            s1_border <= BORDER_ZERO;
            s1_mode   <= PRED_LEFT;
            s1_sof    <= 1'b0;
            s1_eol    <= 1'b0;
            s1_err    <= 1'b0;
        end else begin
            if (s1_en)
                s1_valid <= s_valid;
            if (accept) begin
                // Left and up-left are the previous accepted pixel and its up neighbour.
                s1_x      <= s_pixel;
                s1_a      <= s1_x;
                s1_c      <= s1_b;
                s1_border <= border;
                s1_mode   <= s_sof ? pred_t'(mode) : mode_q;
                s1_sof    <= s_sof;
                s1_eol    <= s_eol;
                s1_err    <= len_err;
                if (s_sof)
                    mode_q <= pred_t'(mode);
                if (s_eol || len_err) begin
                    col       <= '0;
                    first_row <= 1'b0;
                end else begin
                    col       <= eff_col + 1'b1;
                    first_row <= eff_first;
                end
            end
        end
    end

    assign max_ab = (s1_a > s1_b) ? s1_a : s1_b;
    assign min_ab = (s1_a > s1_b) ? s1_b : s1_a;

    always_comb begin
        pred = '0;
        case (s1_border)
            BORDER_ZERO: pred = '0;
            BORDER_LEFT: pred = s1_a;
            BORDER_UP:   pred = s1_b;
            default: begin
                case (s1_mode)
                    PRED_LEFT: pred = s1_a;
                    PRED_UP:   pred = s1_b;
                    PRED_AVG:  pred = PIX_W'(({1'b0, s1_a} + {1'b0, s1_b}) >> 1);
                    default: begin
                        // MED: c between a and b means a smooth gradient, so a + b - c stays in range.
                        if (s1_c >= max_ab)
                            pred = min_ab;
                        else if (s1_c <= min_ab)
                            pred = max_ab;
                        else
                            pred = PIX_W'({1'b0, s1_a} + {1'b0, s1_b} - {1'b0, s1_c});
                    end
                endcase
            end
        endcase
    end

`ifdef DPCM_PRED_MODULO_EN
    logic [PIX_W-1:0] diff_mod;
    assign diff_mod = s1_x - pred;
    assign residual = {diff_mod[PIX_W-1], diff_mod};
`else
    assign residual = {1'b0, s1_x} - {1'b0, pred};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid    <= 1'b0;
            m_residual <= '0;
            m_sof      <= 1'b0;
            m_eol      <= 1'b0;
            err_line   <= 1'b0;
        end else begin
            err_line <= 1'b0;
            if (s2_en) begin
                m_valid  <= s1_valid;
                // Pulse only on the cycle the offending pixel enters the output stage.
                err_line <= s1_valid && s1_err;
                if (s1_valid) begin
                    m_residual <= residual;
                    m_sof      <= s1_sof;
                    m_eol      <= s1_eol;
                end
            end
        end
    end

endmodule
